// File: rtl/rob_mc_if.sv
// rob_mc_if: groups the reorder buffer's decode, writeback, commit and
// operand-lookup signals into one bundle. Signal names carry the _i/_o
// suffix as seen from the ROB itself.
//   alloc_*  : in-order allocation handshake from decode (idx returned)
//   wb_*     : out-of-order completion by entry index
//   commit_* : up to COMMIT_W retiring entries per cycle, slot 0 oldest
//   rs*/hazard : decode source lookup against in-flight producers
// Modports: master = decode/writeback/retire side, slave = the ROB.
interface rob_mc_if #(
  parameter int DEPTH    = 8,
  parameter int COMMIT_W = 2,
  parameter int XLEN     = 32
);
  localparam int IDX_W = $clog2(DEPTH);

  logic                               alloc_valid_i;
  logic                               alloc_ready_o;
  logic [XLEN-1:0]                    alloc_pc_i;
  logic [31:0]                        alloc_instr_i;
  logic [4:0]                         alloc_rd_i;
  logic                               alloc_we_i;
  logic                               alloc_store_i;
  logic [IDX_W-1:0]                   alloc_idx_o;

  logic                               wb_valid_i;
  logic [IDX_W-1:0]                   wb_idx_i;
  logic [XLEN-1:0]                    wb_result_i;
  logic [XLEN-1:0]                    wb_new_pc_i;
  logic                               wb_taken_i;

  logic [COMMIT_W-1:0]                commit_valid_o;
  logic [COMMIT_W-1:0][XLEN-1:0]      commit_pc_o;
  logic [COMMIT_W-1:0][31:0]          commit_instr_o;
  logic [COMMIT_W-1:0][4:0]           commit_rd_o;
  logic [COMMIT_W-1:0][XLEN-1:0]      commit_result_o;
  logic [COMMIT_W-1:0]                commit_we_o;
  logic [COMMIT_W-1:0]                commit_store_o;
  logic [COMMIT_W-1:0][XLEN-1:0]      commit_new_pc_o;
  logic [COMMIT_W-1:0]                commit_taken_o;

  logic [4:0]                         rs1_i;
  logic [4:0]                         rs2_i;
  logic                               rs1_hit_o;
  logic                               rs2_hit_o;
  logic [XLEN-1:0]                    rs1_data_o;
  logic [XLEN-1:0]                    rs2_data_o;
  logic                               hazard_o;

  modport master (
    output alloc_valid_i, alloc_pc_i, alloc_instr_i, alloc_rd_i, alloc_we_i, alloc_store_i,
    input  alloc_ready_o, alloc_idx_o,
    output wb_valid_i, wb_idx_i, wb_result_i, wb_new_pc_i, wb_taken_i,
    input  commit_valid_o, commit_pc_o, commit_instr_o, commit_rd_o, commit_result_o,
    input  commit_we_o, commit_store_o, commit_new_pc_o, commit_taken_o,
    output rs1_i, rs2_i,
    input  rs1_hit_o, rs2_hit_o, rs1_data_o, rs2_data_o, hazard_o
  );

  modport slave (
    input  alloc_valid_i, alloc_pc_i, alloc_instr_i, alloc_rd_i, alloc_we_i, alloc_store_i,
    output alloc_ready_o, alloc_idx_o,
    input  wb_valid_i, wb_idx_i, wb_result_i, wb_new_pc_i, wb_taken_i,
    output commit_valid_o, commit_pc_o, commit_instr_o, commit_rd_o, commit_result_o,
    output commit_we_o, commit_store_o, commit_new_pc_o, commit_taken_o,
    input  rs1_i, rs2_i,
    output rs1_hit_o, rs2_hit_o, rs1_data_o, rs2_data_o, hazard_o
  );
endinterface

// File: rtl/rob_mc.sv
// rob_mc: parametrised reorder buffer. Entries are allocated in order at
// the tail, completed out of order by index, and retired up to COMMIT_W
// per cycle from the head in program order. A retiring taken branch or
// flush_i squashes the whole buffer on the next edge.
// Ports:
//   clk_i, rstn_i (async, active-low), flush_i
//   bus     : rob_mc_if.slave (alloc / wb / commit / lookup groups)
//   count_o : occupied entries (IDX_W+1 bits)
// Build option: define ROB_FWD_EN to forward completed results to decode
// sources; when undefined, hit/data are 0 and any in-flight writer of a
// source raises hazard_o.
module rob_mc #(
  parameter int DEPTH    = 8,
  parameter int COMMIT_W = 2,
  parameter int XLEN     = 32,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         flush_i,
  rob_mc_if.slave      bus,
  output logic [IDX_W:0] count_o
);

  typedef struct packed {
    logic            hit;
    logic            pend;
    logic [XLEN-1:0] data;
  } lookup_t;

  logic [DEPTH-1:0]  valid_q, done_q, we_q, store_q, taken_q;
  logic [XLEN-1:0]   pc_q     [DEPTH];
  logic [XLEN-1:0]   result_q [DEPTH];
  logic [XLEN-1:0]   newPc_q  [DEPTH];
  logic [31:0]       instr_q  [DEPTH];
  logic [4:0]        rd_q     [DEPTH];

  logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]    count_q, count_d, retireCnt;
  logic [IDX_W-1:0]  slotIdx [COMMIT_W];
  logic [COMMIT_W-1:0] slotValid;
  logic              chainOk, takenRetire, flushAll;
  logic              allocTake, wbTake;
  lookup_t           src1, src2;

  // Readiness looks only at the registered count, so a full buffer refuses
  // allocation even in a cycle where commits are freeing entries.
  assign bus.alloc_ready_o = (count_q != (IDX_W+1)'(DEPTH));
  assign bus.alloc_idx_o   = tail_q;
  assign count_o           = count_q;

  assign flushAll  = flush_i | takenRetire;
  assign allocTake = bus.alloc_valid_i & bus.alloc_ready_o & ~flushAll;
  assign wbTake    = bus.wb_valid_i & valid_q[bus.wb_idx_i] & ~flushAll;

  // Retire window: slots stay valid while the chain from the head is
  // completed; a taken branch retires in its own slot and ends the chain.
  always_comb begin
    slotValid   = '0;
    retireCnt   = '0;
    takenRetire = 1'b0;
    chainOk     = 1'b1;
    for (int k = 0; k < COMMIT_W; k++) begin
      slotIdx[k] = head_q + IDX_W'(k);
      if (chainOk && valid_q[slotIdx[k]] && done_q[slotIdx[k]]) begin
        slotValid[k] = 1'b1;
        retireCnt    = retireCnt + (IDX_W+1)'(1);
        if (taken_q[slotIdx[k]]) begin
          takenRetire = 1'b1;
          chainOk     = 1'b0;
        end
      end else begin
        chainOk = 1'b0;
      end
    end
  end

  always_comb begin
    bus.commit_valid_o  = slotValid;
    bus.commit_pc_o     = '0;
    bus.commit_instr_o  = '0;
    bus.commit_rd_o     = '0;
    bus.commit_result_o = '0;
    bus.commit_we_o     = '0;
    bus.commit_store_o  = '0;
    bus.commit_new_pc_o = '0;
    bus.commit_taken_o  = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (slotValid[k]) begin
        bus.commit_pc_o[k]     = pc_q[slotIdx[k]];
        bus.commit_instr_o[k]  = instr_q[slotIdx[k]];
        bus.commit_rd_o[k]     = rd_q[slotIdx[k]];
        bus.commit_result_o[k] = result_q[slotIdx[k]];
        bus.commit_we_o[k]     = we_q[slotIdx[k]];
        bus.commit_store_o[k]  = store_q[slotIdx[k]];
        bus.commit_new_pc_o[k] = newPc_q[slotIdx[k]];
        bus.commit_taken_o[k]  = taken_q[slotIdx[k]];
      end
    end
  end

  // Head wraps naturally: retireCnt == DEPTH truncates to a full lap.
  always_comb begin
    head_d  = head_q + retireCnt[IDX_W-1:0];
    tail_d  = allocTake ? tail_q + IDX_W'(1) : tail_q;
    count_d = count_q + (IDX_W+1)'(allocTake) - retireCnt;
    if (flushAll) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (flushAll) begin
        valid_q <= '0;
        done_q  <= '0;
      end else begin
        for (int k = 0; k < COMMIT_W; k++) begin
          if (slotValid[k]) valid_q[slotIdx[k]] <= 1'b0;
        end
        if (allocTake) begin
          valid_q[tail_q] <= 1'b1;
          done_q[tail_q]  <= 1'b0;
        end
        if (wbTake) done_q[bus.wb_idx_i] <= 1'b1;
      end
    end
  end

  // Payload is never observed unless its entry is valid (and completed for
  // result fields), so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (allocTake) begin
      pc_q[tail_q]    <= bus.alloc_pc_i;
      instr_q[tail_q] <= bus.alloc_instr_i;
      rd_q[tail_q]    <= bus.alloc_rd_i;
      we_q[tail_q]    <= bus.alloc_we_i;
      store_q[tail_q] <= bus.alloc_store_i;
    end
    if (wbTake) begin
      result_q[bus.wb_idx_i] <= bus.wb_result_i;
      newPc_q[bus.wb_idx_i]  <= bus.wb_new_pc_i;
      taken_q[bus.wb_idx_i]  <= bus.wb_taken_i;
    end
  end

  // Walks backward from tail-1 so the first match is the youngest producer;
  // invalid slots outside head..tail-1 are skipped by the valid check.
  function automatic lookup_t lookupSrc(input logic [4:0] rs);
    lookup_t res;
    logic [IDX_W-1:0] idx;
`ifdef ROB_FWD_EN
    logic found;
    found = 1'b0;
`endif
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = tail_q - IDX_W'(i + 1);
      if (rs != 5'd0 && valid_q[idx] && we_q[idx] && rd_q[idx] == rs) begin
`ifdef ROB_FWD_EN
        if (!found) begin
          found    = 1'b1;
          res.hit  = done_q[idx];
          res.pend = ~done_q[idx];
          res.data = done_q[idx] ? result_q[idx] : '0;
        end
`else
        res.pend = 1'b1;
`endif
      end
    end
    return res;
  endfunction

  always_comb begin
    src1 = lookupSrc(bus.rs1_i);
    src2 = lookupSrc(bus.rs2_i);
  end

  assign bus.rs1_hit_o  = src1.hit;
  assign bus.rs2_hit_o  = src2.hit;
  assign bus.rs1_data_o = src1.data;
  assign bus.rs2_data_o = src2.data;
  assign bus.hazard_o   = src1.pend | src2.pend;

endmodule

// File: tb/tb_rob_mc.sv
// tb_rob_mc: self-checking bench for rob_mc. Every allocation pushes its
// expected commit record onto a scoreboard queue; each cycle the commit
// slots are popped and compared in order. Directed checks cover reset,
// full/ready, out-of-order completion, taken-branch squash, lookup,
// pointer wrap and flush. Lookup expectations follow ROB_FWD_EN.
module tb_rob_mc;
  localparam int DEPTH    = 8;
  localparam int COMMIT_W = 2;
  localparam int XLEN     = 32;
  localparam int IDX_W    = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  logic [IDX_W:0] count;

  rob_mc_if #(.DEPTH(DEPTH), .COMMIT_W(COMMIT_W), .XLEN(XLEN)) bus ();

  rob_mc #(.DEPTH(DEPTH), .COMMIT_W(COMMIT_W), .XLEN(XLEN)) dut (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .flush_i (flush),
    .bus     (bus),
    .count_o (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] result;
    logic [31:0] newPc;
    logic [4:0]  rd;
    logic        we;
    logic        st;
    logic        tk;
  } rec_t;

  rec_t expQ[$];
  rec_t model [DEPTH];
  int   mTail = 0;
  int   testsRun = 0;
  int   testsFailed = 0;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Compares every commit slot against the scoreboard; idle slots must be 0.
  task automatic checkCommits();
    rec_t r;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (bus.commit_valid_o[k]) begin
        if (k > 0) checkOutput("commit_in_order", bus.commit_valid_o[k-1], 1);
        if (expQ.size() == 0) begin
          checkOutput("commit_unexpected", bus.commit_valid_o[k], 0);
        end else begin
          r = expQ.pop_front();
          checkOutput("commit_pc",     bus.commit_pc_o[k],     r.pc);
          checkOutput("commit_instr",  bus.commit_instr_o[k],  r.instr);
          checkOutput("commit_rd",     bus.commit_rd_o[k],     r.rd);
          checkOutput("commit_result", bus.commit_result_o[k], r.result);
          checkOutput("commit_we",     bus.commit_we_o[k],     r.we);
          checkOutput("commit_store",  bus.commit_store_o[k],  r.st);
          checkOutput("commit_taken",  bus.commit_taken_o[k],  r.tk);
          checkOutput("commit_new_pc", bus.commit_new_pc_o[k], r.newPc);
          if (r.tk) begin
            expQ.delete();
            mTail = 0;
          end
        end
      end else begin
        checkOutput("idle_slot_pc",     bus.commit_pc_o[k],     0);
        checkOutput("idle_slot_result", bus.commit_result_o[k], 0);
        checkOutput("idle_slot_we",     bus.commit_we_o[k],     0);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    checkCommits();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit aEn, input logic [31:0] pc, input logic [4:0] rd,
                               input bit we, input bit st, input logic [31:0] res,
                               input bit tk, input logic [31:0] npc,
                               input bit wEn, input int wIdx);
    rec_t r;
    if (aEn) begin
      checkOutput("alloc_ready", bus.alloc_ready_o, 1);
      checkOutput("alloc_idx",   bus.alloc_idx_o,   mTail);
      r.pc = pc; r.instr = pc ^ 32'h0000_0013; r.rd = rd; r.we = we; r.st = st;
      r.result = res; r.tk = tk; r.newPc = npc;
      bus.alloc_pc_i    = pc;
      bus.alloc_instr_i = r.instr;
      bus.alloc_rd_i    = rd;
      bus.alloc_we_i    = we;
      bus.alloc_store_i = st;
      model[mTail] = r;
      expQ.push_back(r);
      mTail = (mTail + 1) % DEPTH;
    end
    bus.alloc_valid_i = aEn;
    if (wEn) begin
      bus.wb_valid_i  = 1'b1;
      bus.wb_idx_i    = IDX_W'(wIdx);
      bus.wb_result_i = model[wIdx].result;
      bus.wb_new_pc_i = model[wIdx].newPc;
      bus.wb_taken_i  = model[wIdx].tk;
    end
    tick();
    bus.alloc_valid_i = 1'b0;
    bus.wb_valid_i    = 1'b0;
  endtask

  task automatic doAlloc(input logic [31:0] pc, input logic [4:0] rd, input bit we, input logic [31:0] res);
    applyStimulus(1, pc, rd, we, 0, res, 0, 32'h0, 0, 0);
  endtask

  task automatic doWb(input int idx);
    applyStimulus(0, 32'h0, 5'd0, 0, 0, 32'h0, 0, 32'h0, 1, idx);
  endtask

  task automatic idle();
    applyStimulus(0, 32'h0, 5'd0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  // Flush cycle; optional alloc (rd=12) and wb presented alongside must be dropped.
  task automatic doFlush(input bit aEn, input bit wEn, input int wIdx);
    flush             = 1'b1;
    bus.alloc_valid_i = aEn;
    bus.alloc_pc_i    = 32'h6100;
    bus.alloc_instr_i = 32'h6113;
    bus.alloc_rd_i    = 5'd12;
    bus.alloc_we_i    = 1'b1;
    bus.alloc_store_i = 1'b0;
    bus.wb_valid_i    = wEn;
    bus.wb_idx_i      = IDX_W'(wIdx);
    bus.wb_result_i   = 32'hDEAD;
    bus.wb_new_pc_i   = 32'h0;
    bus.wb_taken_i    = 1'b0;
    tick();
    flush             = 1'b0;
    bus.alloc_valid_i = 1'b0;
    bus.wb_valid_i    = 1'b0;
    expQ.delete();
    mTail = 0;
  endtask

  task automatic setSrc(input logic [4:0] a, input logic [4:0] b);
    bus.rs1_i = a;
    bus.rs2_i = b;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.alloc_valid_i = 0; bus.alloc_pc_i = 0; bus.alloc_instr_i = 0; bus.alloc_rd_i = 0;
    bus.alloc_we_i = 0; bus.alloc_store_i = 0;
    bus.wb_valid_i = 0; bus.wb_idx_i = 0; bus.wb_result_i = 0; bus.wb_new_pc_i = 0; bus.wb_taken_i = 0;
    bus.rs1_i = 0; bus.rs2_i = 0;

    // Reset state
    #12;
    checkOutput("rst_count",  count, 0);
    checkOutput("rst_ready",  bus.alloc_ready_o, 1);
    checkOutput("rst_idx",    bus.alloc_idx_o, 0);
    checkOutput("rst_commit", bus.commit_valid_o, 0);
    checkOutput("rst_hazard", bus.hazard_o, 0);
    checkOutput("rst_hit",    bus.rs1_hit_o, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Fill to DEPTH, ready drops, ninth request refused
    for (int i = 0; i < DEPTH; i++) doAlloc(32'h100 + 32'(4 * i), 5'd0, 0, 32'(i));
    checkOutput("full_count", count, 8);
    checkOutput("full_ready", bus.alloc_ready_o, 0);
    bus.alloc_valid_i = 1'b1;
    tick();
    bus.alloc_valid_i = 1'b0;
    checkOutput("full_count_after_9th", count, 8);
    checkOutput("full_idx_after_9th", bus.alloc_idx_o, 0);
    doFlush(0, 0, 0);
    checkOutput("flush1_count", count, 0);

    // Out-of-order writeback 3,1,0,2 with in-order dual commit
    doAlloc(32'h1000, 5'd2, 1, 32'h11);
    doAlloc(32'h1004, 5'd3, 1, 32'h22);
    applyStimulus(1, 32'h1008, 5'd0, 0, 1, 32'h33, 0, 32'h0, 0, 0);
    doAlloc(32'h100C, 5'd4, 1, 32'h44);
    doWb(3);
    doWb(1);
    checkOutput("ooo_no_commit", bus.commit_valid_o, 2'b00);
    doWb(0);
    checkOutput("ooo_commit01", bus.commit_valid_o, 2'b11);
    doWb(2);
    checkOutput("ooo_commit23", bus.commit_valid_o, 2'b11);
    idle();
    checkOutput("ooo_count", count, 0);

    // Taken branch retires alone and squashes younger entries
    doFlush(0, 0, 0);
    applyStimulus(1, 32'h2000, 5'd0, 0, 0, 32'h2004, 1, 32'h100, 0, 0);
    doAlloc(32'h2004, 5'd6, 1, 32'h66);
    doAlloc(32'h2008, 5'd7, 1, 32'h67);
    doWb(1);
    doWb(0);
    checkOutput("br_slot0_only", bus.commit_valid_o, 2'b01);
    idle();
    checkOutput("br_count", count, 0);
    checkOutput("br_tail", bus.alloc_idx_o, 0);
    checkOutput("br_no_commit", bus.commit_valid_o, 2'b00);

    // Youngest-producer lookup
    doAlloc(32'h3000, 5'd1, 1, 32'h31);
    doAlloc(32'h3004, 5'd5, 1, 32'hAA);
    doAlloc(32'h3008, 5'd7, 1, 32'h77);
    doAlloc(32'h300C, 5'd5, 1, 32'hBB);
    doWb(1);
    setSrc(5'd5, 5'd0);
    checkOutput("lk_pend_hazard", bus.hazard_o, 1);
    checkOutput("lk_pend_hit",    bus.rs1_hit_o, 0);
    setSrc(5'd9, 5'd0);
    checkOutput("lk_miss_hazard", bus.hazard_o, 0);
    checkOutput("lk_miss_data",   bus.rs1_data_o, 0);
    doWb(3);
    setSrc(5'd5, 5'd5);
`ifdef ROB_FWD_EN
    checkOutput("lk_fwd_hit1",   bus.rs1_hit_o, 1);
    checkOutput("lk_fwd_data1",  bus.rs1_data_o, 32'hBB);
    checkOutput("lk_fwd_hit2",   bus.rs2_hit_o, 1);
    checkOutput("lk_fwd_data2",  bus.rs2_data_o, 32'hBB);
    checkOutput("lk_fwd_hazard", bus.hazard_o, 0);
`else
    checkOutput("lk_nofwd_hit1",   bus.rs1_hit_o, 0);
    checkOutput("lk_nofwd_data2",  bus.rs2_data_o, 0);
    checkOutput("lk_nofwd_hazard", bus.hazard_o, 1);
`endif
    setSrc(5'd0, 5'd7);
    checkOutput("lk_rs2_pend_hazard", bus.hazard_o, 1);
    setSrc(5'd0, 5'd0);
    checkOutput("lk_zero_hazard", bus.hazard_o, 0);
    doWb(0);
    doWb(2);
    idle();
    checkOutput("lk_count", count, 0);
    setSrc(5'd5, 5'd0);
    checkOutput("lk_gone_hazard", bus.hazard_o, 0);
    checkOutput("lk_gone_hit",    bus.rs1_hit_o, 0);
    setSrc(5'd0, 5'd0);

    // Pointer wrap with simultaneous alloc + writeback + retire
    doFlush(0, 0, 0);
    for (int i = 0; i <= 6; i++) begin
      applyStimulus(i < 6, 32'h4000 + 32'(4 * i), 5'(8 + i), 1, 0, 32'h400 + 32'(i), 0, 32'h0, i > 0, i - 1);
      if (i == 3) checkOutput("wrap_count_mid", count, 2);
    end
    idle();
    idle();
    checkOutput("wrap_count_drained", count, 0);
    checkOutput("wrap_tail", bus.alloc_idx_o, 6);
    for (int i = 0; i < 4; i++) doAlloc(32'h5000 + 32'(4 * i), 5'(20 + i), 1, 32'h500 + 32'(i));
    checkOutput("wrap_count_4", count, 4);
    doWb(1);
    doWb(0);
    doWb(7);
    checkOutput("wrap_head_blocked", bus.commit_valid_o, 2'b00);
    doWb(6);
    idle();
    idle();
    checkOutput("wrap_count_end", count, 0);

    // Flush drops same-cycle alloc and writeback
    doAlloc(32'h6000, 5'd12, 1, 32'h66);
    doAlloc(32'h6004, 5'd13, 1, 32'h67);
    doFlush(1, 1, 2);
    checkOutput("fl_count",  count, 0);
    checkOutput("fl_ready",  bus.alloc_ready_o, 1);
    checkOutput("fl_idx",    bus.alloc_idx_o, 0);
    checkOutput("fl_commit", bus.commit_valid_o, 2'b00);
    setSrc(5'd12, 5'd13);
    checkOutput("fl_no_entry_hazard", bus.hazard_o, 0);
    setSrc(5'd0, 5'd0);
    idle();
    checkOutput("fl_count_idle", count, 0);

    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
